// File: rtl/btc_miner_pkg.sv
// Shared register map, bit positions and result entry layout for the multi-core miner register block.
package btc_miner_pkg;

   localparam int unsigned HDR_WORDS = 19;
   localparam int unsigned CORE_ID_W = 3;

   localparam int unsigned REG_CONFIG      = 'h00;
   localparam int unsigned REG_HDR0        = 'h04;
   localparam int unsigned REG_NONCE_BASE  = 'h50;
   localparam int unsigned REG_CTRL        = 'h54;
   localparam int unsigned REG_STATUS      = 'h58;
   localparam int unsigned REG_RESULT      = 'h5C;
   localparam int unsigned REG_RESULT_CORE = 'h60;

   localparam int unsigned CFG_USE_NONCE_IN = 0;
   localparam int unsigned CFG_ONESHOT      = 1;
   localparam int unsigned CFG_IRQ_EN       = 2;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_STOP  = 1;
   localparam int unsigned CTRL_FLUSH = 2;

   localparam int unsigned ST_EMPTY     = 8;
   localparam int unsigned ST_FULL      = 9;
   localparam int unsigned ST_OVERFLOW  = 10;
   localparam int unsigned ST_COUNT_LSB = 16;

   typedef struct packed {
      logic [CORE_ID_W-1:0] core_id;
      logic [31:0]          nonce;
   } result_t;

   function automatic int unsigned core_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] wr_v,
                                              input logic [3:0] sel);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? wr_v[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/btc_miner_regs_mc_fifo.sv
// Synchronous result FIFO: push/pop/flush, head word always visible on dout.
module btc_result_fifo #(
   parameter int unsigned WIDTH = 35,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/btc_miner_regs_mc.sv
// Wishbone register block for a multi-core miner: header, nonce slicing, start/stop, result collection.
module btc_miner_regs_mc
   import btc_miner_pkg::*;
#(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 8
) (
   input  logic                   clk,
   input  logic                   wbRst,
   input  logic [ADDR_W-1:0]      wbAddr,
   input  logic [3:0]             wbSel,
   input  logic                   wbWe,
   input  logic [31:0]            wbWData,
   input  logic                   wbCycle,
   input  logic                   wbStrobe,
   input  logic [2:0]             wbCti,
   input  logic [1:0]             wbBte,
   output logic [31:0]            wbRData,
   output logic                   wbAck,
   output logic                   wbErr,
   output logic                   wbRty,
   output logic [HDR_WORDS*32-1:0] header,
   output logic [NUM_CORES*32-1:0] core_nonce_start,
   output logic                   start,
   output logic                   stop,
   output logic                   cfg_use_nonce_in,
   output logic                   cfg_oneshot,
   input  logic [NUM_CORES*32-1:0] core_nonce,
   input  logic [NUM_CORES-1:0]   core_found,
   input  logic [NUM_CORES-1:0]   core_done,
   output logic                   irq
);
   localparam int unsigned SEL_W    = core_id_w(NUM_CORES);
   localparam int unsigned SLICE_SH = 32 - $clog2(NUM_CORES);
   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]          hdr [HDR_WORDS];
   logic [31:0]          nonce_start [NUM_CORES];
   logic [31:0]          pend_nonce [NUM_CORES];
   logic [NUM_CORES-1:0] pend_valid, pend_clr, pend_load;
   logic [31:0]          nonce_base, rd_data;
   logic                 cfg_irq_en, overflow, ovf_event, ovf_clr;
   logic [ADDR_W-1:0]    reg_addr;
   logic                 access, wr_act, rd_act, ctrl_wr;
   logic                 do_start, do_stop, flush, pop, push_ok;
   logic [SEL_W-1:0]     push_idx;
   result_t              push_ent, head;
   logic                 fifo_empty, fifo_full;
   logic [CNT_W-1:0]     fifo_count;
   logic                 unused_bits;

   assign unused_bits = ^{wbCti, wbBte, wbAddr[1:0]};

   assign reg_addr = {wbAddr[ADDR_W-1:2], 2'b00};
   assign access   = wbCycle & wbStrobe;
   assign wr_act   = access & ~wbAck & wbWe;
   assign rd_act   = access & ~wbAck & ~wbWe;
   assign ctrl_wr  = wr_act & (reg_addr == ADDR_W'(REG_CTRL)) & wbSel[0];
   assign do_stop  = ctrl_wr & wbWData[CTRL_STOP];
   assign do_start = ctrl_wr & wbWData[CTRL_START] & ~wbWData[CTRL_STOP];
   assign flush    = ctrl_wr & wbWData[CTRL_FLUSH];
   assign pop      = rd_act & (reg_addr == ADDR_W'(REG_RESULT)) & ~fifo_empty;
   assign ovf_clr  = wr_act & (reg_addr == ADDR_W'(REG_STATUS)) & wbSel[1] & wbWData[ST_OVERFLOW];

   assign wbErr = 1'b0;
   assign wbRty = 1'b0;
   assign irq   = cfg_irq_en & ~fifo_empty;

   for (genvar k = 0; k < HDR_WORDS; k++) begin : g_hdr
      assign header[32*k +: 32] = hdr[k];
   end
   for (genvar i = 0; i < NUM_CORES; i++) begin : g_start
      assign core_nonce_start[32*i +: 32] = nonce_start[i];
   end

   // Register file, nonce slicer and start/stop pulses.
   always_ff @(posedge clk) begin
      if (wbRst) begin
         for (int k = 0; k < HDR_WORDS; k++) hdr[k] <= '0;
         for (int i = 0; i < NUM_CORES; i++) nonce_start[i] <= '0;
         nonce_base       <= '0;
         cfg_use_nonce_in <= 1'b0;
         cfg_oneshot      <= 1'b0;
         cfg_irq_en       <= 1'b0;
         start            <= 1'b0;
         stop             <= 1'b0;
      end else begin
         start <= do_start;
         stop  <= do_stop;
         if (wr_act) begin
            if (reg_addr == ADDR_W'(REG_CONFIG) && wbSel[0]) begin
               cfg_use_nonce_in <= wbWData[CFG_USE_NONCE_IN];
               cfg_oneshot      <= wbWData[CFG_ONESHOT];
               cfg_irq_en       <= wbWData[CFG_IRQ_EN];
            end
            for (int k = 0; k < HDR_WORDS; k++)
               if (reg_addr == ADDR_W'(REG_HDR0 + 4*k)) hdr[k] <= byte_merge(hdr[k], wbWData, wbSel);
            if (reg_addr == ADDR_W'(REG_NONCE_BASE)) nonce_base <= byte_merge(nonce_base, wbWData, wbSel);
         end
         if (do_start)
            for (int i = 0; i < NUM_CORES; i++)
               nonce_start[i] <= (cfg_use_nonce_in ? nonce_base : 32'd0) + 32'(64'(i) << SLICE_SH);
      end
   end

   // Lowest-index pending core gets the single push slot.
   always_comb begin
      push_idx = '0;
      pend_clr = '0;
      for (int i = int'(NUM_CORES) - 1; i >= 0; i--)
         if (pend_valid[i]) push_idx = SEL_W'(i);
      push_ok = (|pend_valid) & (~fifo_full | pop);
      if (push_ok) pend_clr[push_idx] = 1'b1;
      push_ent.core_id = CORE_ID_W'(push_idx);
      push_ent.nonce   = pend_nonce[push_idx];
   end

   assign pend_load = core_found & (~pend_valid | pend_clr);
   assign ovf_event = ~flush & (|(core_found & pend_valid & ~pend_clr));

   always_ff @(posedge clk) begin
      if (wbRst) begin
         pend_valid <= '0;
         for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= '0;
      end else if (flush) begin
         pend_valid <= '0;
      end else begin
         pend_valid <= (pend_valid & ~pend_clr) | core_found;
         for (int i = 0; i < NUM_CORES; i++)
            if (pend_load[i]) pend_nonce[i] <= core_nonce[32*i +: 32];
      end
   end

   // A fresh drop outranks a software clear in the same cycle.
   always_ff @(posedge clk) begin
      if (wbRst)          overflow <= 1'b0;
      else if (ovf_event) overflow <= 1'b1;
      else if (ovf_clr)   overflow <= 1'b0;
   end

   btc_result_fifo #(.WIDTH($bits(result_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (wbRst),
      .flush (flush),
      .push  (push_ok),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   always_comb begin
      rd_data = '0;
      case (reg_addr)
         ADDR_W'(REG_CONFIG): begin
            rd_data[CFG_USE_NONCE_IN] = cfg_use_nonce_in;
            rd_data[CFG_ONESHOT]      = cfg_oneshot;
            rd_data[CFG_IRQ_EN]       = cfg_irq_en;
         end
         ADDR_W'(REG_NONCE_BASE): rd_data = nonce_base;
         ADDR_W'(REG_STATUS): begin
            rd_data[7:0]               = 8'(core_done);
            rd_data[ST_EMPTY]          = fifo_empty;
            rd_data[ST_FULL]           = fifo_full;
            rd_data[ST_OVERFLOW]       = overflow;
            rd_data[ST_COUNT_LSB +: 8] = 8'(fifo_count);
         end
         ADDR_W'(REG_RESULT):      rd_data = fifo_empty ? 32'd0 : head.nonce;
         ADDR_W'(REG_RESULT_CORE): rd_data = fifo_empty ? 32'd0 : 32'(head.core_id);
         default: begin
            for (int k = 0; k < HDR_WORDS; k++)
               if (reg_addr == ADDR_W'(REG_HDR0 + 4*k)) rd_data = hdr[k];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wbRst) begin
         wbAck   <= 1'b0;
         wbRData <= '0;
      end else begin
         wbAck <= access & ~wbAck;
         if (rd_act) wbRData <= rd_data;
      end
   end

endmodule

// File: tb/tb_btc_miner_regs_mc.sv
// Self-checking bench: queue-based reference model compared every cycle plus directed literal checks.
module tb_btc_miner_regs_mc;
   localparam int NC    = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              wbRst, wbWe, wbCycle, wbStrobe;
   logic [7:0]        wbAddr;
   logic [3:0]        wbSel;
   logic [31:0]       wbWData, wbRData;
   logic [2:0]        wbCti;
   logic [1:0]        wbBte;
   logic              wbAck, wbErr, wbRty;
   logic [19*32-1:0]  header;
   logic [NC*32-1:0]  core_nonce_start, core_nonce;
   logic              start, stop, cfg_use_nonce_in, cfg_oneshot, irq;
   logic [NC-1:0]     core_found, core_done;

   btc_miner_regs_mc #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .ADDR_W(8)) dut (
      .clk(clk), .wbRst(wbRst), .wbAddr(wbAddr), .wbSel(wbSel), .wbWe(wbWe), .wbWData(wbWData),
      .wbCycle(wbCycle), .wbStrobe(wbStrobe), .wbCti(wbCti), .wbBte(wbBte), .wbRData(wbRData),
      .wbAck(wbAck), .wbErr(wbErr), .wbRty(wbRty), .header(header), .core_nonce_start(core_nonce_start),
      .start(start), .stop(stop), .cfg_use_nonce_in(cfg_use_nonce_in), .cfg_oneshot(cfg_oneshot),
      .core_nonce(core_nonce), .core_found(core_found), .core_done(core_done), .irq(irq)
   );

   int n_chk = 0, n_fail = 0, start_cnt = 0;
   bit chk_en = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct { int cid; logic [31:0] nonce; } ent_t;
   ent_t        q[$];
   logic [31:0] m_hdr [19];
   logic [31:0] m_cns [NC];
   logic [31:0] m_pn  [NC];
   bit          m_pv  [NC];
   logic [31:0] m_base, m_rdata;
   bit          m_use, m_one, m_irqen, m_start, m_stop, m_ack, m_rd, m_ovf;

   function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input int w);
      if (w == 0) return {29'd0, m_irqen, m_one, m_use};
      if (w >= 1 && w <= 19) return m_hdr[w-1];
      if (w == 20) return m_base;
      if (w == 22) return {8'h0, 8'(q.size()), 5'h0, m_ovf, q.size() == DEPTH, q.size() == 0, 8'(core_done)};
      if (w == 23) return (q.size() > 0) ? q[0].nonce : 32'd0;
      if (w == 24) return (q.size() > 0) ? 32'(q[0].cid) : 32'd0;
      return 32'd0;
   endfunction

   always @(posedge clk) begin : model
      bit act, pop, flush, clr, ovf_ev;
      int w, pc;
      if (wbRst) begin
         foreach (m_hdr[k]) m_hdr[k] = 0;
         foreach (m_cns[i]) begin m_cns[i] = 0; m_pv[i] = 0; end
         m_base = 0; m_use = 0; m_one = 0; m_irqen = 0; m_start = 0; m_stop = 0;
         m_ack = 0; m_rd = 0; m_rdata = 0; m_ovf = 0;
         q.delete();
      end else begin
         act = wbCycle && wbStrobe && !m_ack;
         m_ack = act;
         w = int'(wbAddr[7:2]);
         m_start = 0; m_stop = 0; pop = 0; flush = 0; clr = 0; ovf_ev = 0;
         if (act && !wbWe) begin
            m_rdata = m_read(w); m_rd = 1;
            pop = (w == 23) && (q.size() > 0);
         end else if (act) m_rd = 0;
         if (act && wbWe) begin
            if (w == 0 && wbSel[0]) begin m_use = wbWData[0]; m_one = wbWData[1]; m_irqen = wbWData[2]; end
            if (w >= 1 && w <= 19) m_hdr[w-1] = bm(m_hdr[w-1], wbWData, wbSel);
            if (w == 20) m_base = bm(m_base, wbWData, wbSel);
            if (w == 21 && wbSel[0]) begin
               if (wbWData[1]) m_stop = 1;
               else if (wbWData[0]) begin
                  m_start = 1;
                  for (int i = 0; i < NC; i++)
                     m_cns[i] = 32'((m_use ? 64'(m_base) : 64'd0) + 64'(i) * (64'h1_0000_0000 / NC));
               end
               flush = wbWData[2];
            end
            if (w == 22) clr = wbSel[1] && wbWData[10];
         end
         if (flush) begin
            q.delete();
            foreach (m_pv[i]) m_pv[i] = 0;
         end else begin
            if (pop) void'(q.pop_front());
            pc = -1;
            for (int i = NC - 1; i >= 0; i--) if (m_pv[i]) pc = i;
            if (pc >= 0 && q.size() < DEPTH) begin
               q.push_back('{pc, m_pn[pc]});
               m_pv[pc] = 0;
            end
            for (int i = 0; i < NC; i++)
               if (core_found[i]) begin
                  if (m_pv[i]) ovf_ev = 1;
                  else begin m_pv[i] = 1; m_pn[i] = core_nonce[32*i +: 32]; end
               end
         end
         if (clr) m_ovf = 0;
         if (ovf_ev) m_ovf = 1;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("wbAck", 32'(wbAck), 32'(m_ack));
         if (m_ack && m_rd) check("wbRData", wbRData, m_rdata);
         check("start", 32'(start), 32'(m_start));
         check("stop", 32'(stop), 32'(m_stop));
         check("irq", 32'(irq), 32'(m_irqen && (q.size() > 0)));
         check("cfg", {30'd0, cfg_oneshot, cfg_use_nonce_in}, {30'd0, m_one, m_use});
         check("err_rty", {30'd0, wbErr, wbRty}, 32'd0);
         for (int k = 0; k < 19; k++) check("header", header[32*k +: 32], m_hdr[k]);
         for (int i = 0; i < NC; i++) check("nonce_start", core_nonce_start[32*i +: 32], m_cns[i]);
      end
   end

   always @(negedge clk) if (start === 1'b1) start_cnt++;

   task automatic wb_cycle(input logic [7:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
      int n;
      @(negedge clk);
      wbAddr = a; wbWe = we; wbWData = d; wbSel = s; wbCycle = 1; wbStrobe = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wbAck && n < 8);
      check("ack_seen", 32'(wbAck), 32'd1);
      rd = wbRData;
      wbCycle = 0; wbStrobe = 0; wbWe = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      wb_cycle(a, 1'b1, d, 4'hF, dummy);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      wb_cycle(a, 1'b0, 32'd0, 4'hF, d);
   endtask

   task automatic hit1(input int c, input logic [31:0] n);
      @(negedge clk);
      core_found = '0; core_found[c] = 1'b1; core_nonce[32*c +: 32] = n;
      @(negedge clk);
      core_found = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      wbRst = 1; wbAddr = 0; wbSel = 0; wbWe = 0; wbWData = 0; wbCycle = 0; wbStrobe = 0;
      wbCti = 0; wbBte = 0; core_nonce = '0; core_found = '0; core_done = '0;
      repeat (3) @(negedge clk);
      wbRst = 0; chk_en = 1;
      check("rst_start", 32'(start), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_hdr0", header[31:0], 32'd0);
      rd(8'h58, r); check("rst_status", r, 32'h0000_0100);

      for (int k = 0; k < 19; k++) wr(8'(4 + 4*k), 32'h1000 + 32'(k));
      for (int k = 0; k < 19; k++) begin
         rd(8'(4 + 4*k), r);
         check("hdr_rd", r, 32'h1000 + 32'(k));
         check("hdr_port", header[32*k +: 32], 32'h1000 + 32'(k));
      end

      wb_cycle(8'h50, 1'b1, 32'hAABB_CCDD, 4'b0101, r);
      rd(8'h50, r); check("base_bytemask", r, 32'h00BB_00DD);

      wr(8'h00, 32'h1); wr(8'h50, 32'hF000_0000); wr(8'h54, 32'h1);
      repeat (3) @(negedge clk);
      check("start_once", 32'(start_cnt), 32'd1);
      check("slice0", core_nonce_start[31:0],   32'hF000_0000);
      check("slice1", core_nonce_start[63:32],  32'h3000_0000);
      check("slice2", core_nonce_start[95:64],  32'h7000_0000);
      check("slice3", core_nonce_start[127:96], 32'hB000_0000);

      wr(8'h54, 32'h3);
      repeat (2) @(negedge clk);
      check("stop_wins", 32'(start_cnt), 32'd1);
      check("slice_held", core_nonce_start[63:32], 32'h3000_0000);
      wr(8'h00, 32'h0); wr(8'h54, 32'h1);
      @(negedge clk);
      check("slice3_nobase", core_nonce_start[127:96], 32'hC000_0000);

      @(negedge clk);
      core_found = 4'b1101; core_nonce = {32'hC, 32'hB, 32'h0, 32'hA};
      @(negedge clk); core_found = '0;
      repeat (4) @(negedge clk);
      rd(8'h58, r); check("count3", (r >> 16) & 32'hFF, 32'd3);
      rd(8'h60, r); check("core_a", r, 32'd0);
      rd(8'h5C, r); check("res_a", r, 32'hA);
      rd(8'h60, r); check("core_b", r, 32'd2);
      rd(8'h5C, r); check("res_b", r, 32'hB);
      rd(8'h60, r); check("core_c", r, 32'd3);
      rd(8'h5C, r); check("res_c", r, 32'hC);
      rd(8'h5C, r); check("res_empty", r, 32'd0);

      core_done = 4'b0101;
      for (int j = 0; j < 9; j++) hit1(1, 32'h100 + 32'(j));
      repeat (3) @(negedge clk);
      rd(8'h58, r); check("status_full", r, 32'h0008_0205);
      hit1(1, 32'h1FF);
      repeat (2) @(negedge clk);
      rd(8'h58, r); check("status_ovf", r, 32'h0008_0605);
      rd(8'h5C, r); check("pop_full", r, 32'h100);
      rd(8'h58, r); check("status_refill", r, 32'h0008_0605);

      wr(8'h54, 32'h4);
      rd(8'h58, r); check("status_flush", r, 32'h0000_0505);
      wr(8'h00, 32'h4);
      check("irq_idle", 32'(irq), 32'd0);
      hit1(3, 32'h55);
      repeat (2) @(negedge clk);
      check("irq_set", 32'(irq), 32'd1);
      rd(8'h60, r); check("core_55", r, 32'd3);
      rd(8'h5C, r); check("res_55", r, 32'h55);
      check("irq_drained", 32'(irq), 32'd0);
      wr(8'h58, 32'h400);
      rd(8'h58, r); check("ovf_w1c", r, 32'h0000_0105);

      hit1(2, 32'h77);
      repeat (2) @(negedge clk);
      check("irq_pre_rst", 32'(irq), 32'd1);
      @(negedge clk);
      wbAddr = 8'h58; wbWe = 0; wbSel = 4'hF; wbCycle = 1; wbStrobe = 1;
      @(negedge clk);
      check("ack_pre_rst", 32'(wbAck), 32'd1);
      wbRst = 1;
      @(negedge clk);
      check("rst_ack", 32'(wbAck), 32'd0);
      check("rst_rdata", wbRData, 32'd0);
      check("rst_irq2", 32'(irq), 32'd0);
      check("rst_pulses", {30'd0, start, stop}, 32'd0);
      check("rst_hdr", header[31:0], 32'd0);
      check("rst_slice", core_nonce_start[63:32], 32'd0);
      wbRst = 0; wbCycle = 0; wbStrobe = 0; core_done = '0;
      rd(8'h58, r); check("status_after_rst", r, 32'h0000_0100);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
